// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // ex_mem_to_reg encoding that marks a load in EX.
    localparam logic [1:0] MEM_TO_REG_LOAD = 2'b01;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID source that depends on a load still in EX.
// Register x0 never creates a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic [1:0] ex_mem_to_reg,
    output logic       hazard
);

    // Hazard when a writing load targets a non-zero register that ID reads.
    always_comb begin
        hazard = ex_reg_write
              && (ex_mem_to_reg == MEM_TO_REG_LOAD)
              && (ex_rd != 5'd0)
              && ((id_use_rs1 && (id_rs1 == ex_rd))
               || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory wait with
// timeout, and mispredict flushes. Priority: memory wait > mispredict >
// load-use. Control outputs are combinational and forced low during reset.
// Optional macro HAZARD_PERF_CNT_EN adds the stall/flush performance counters;
// without it both counter outputs are tied to zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic [1:0]  ex_mem_to_reg,
    input  logic        mispredict,
    input  logic        mem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_bubble,
    output logic        ex_mem_hold,
    output logic        mem_wb_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [7:0] WAIT_MAX     = 8'(MEM_WAIT_MAX);
    // Flush cycles still owed after the one in which the flush starts.
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [1:0] flush_rem, flush_rem_nxt;
    logic       pending, pending_nxt;
    logic       timeout_nxt;
    logic       load_use, mem_stall;
    logic       stall_set, flush_set, lu_set;

    load_use_detect u_load_use_detect (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .hazard        (load_use)
    );

    assign mem_stall = mem_req && !dmem_ready;

    // Next-state and control decode; memory wait outranks flush, flush outranks load-use.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        flush_rem_nxt = flush_rem;
        pending_nxt   = pending;
        timeout_nxt   = mem_timeout;
        stall_set     = 1'b0;
        flush_set     = 1'b0;
        lu_set        = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    stall_set    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd0;
                    if (mispredict) pending_nxt = 1'b1;
                end else if (mispredict || pending) begin
                    flush_set   = 1'b1;
                    pending_nxt = 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = FLUSH;
                        flush_rem_nxt = FLUSH_RELOAD;
                    end
                end else if (load_use) begin
                    lu_set = 1'b1;
                end
            end
            MEM_WAIT: begin
                // A mispredict seen while waiting is replayed once RUN resumes.
                if (mispredict) pending_nxt = 1'b1;
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    stall_set = 1'b1;
                    if (wait_cnt + 8'd1 == WAIT_MAX) begin
                        timeout_nxt  = 1'b1;
                        state_nxt    = RUN;
                        wait_cnt_nxt = 8'd0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    // Interrupted flush restarts from scratch after the wait.
                    stall_set     = 1'b1;
                    state_nxt     = MEM_WAIT;
                    wait_cnt_nxt  = 8'd0;
                    pending_nxt   = 1'b1;
                    flush_rem_nxt = 2'd0;
                end else begin
                    flush_set = 1'b1;
                    if (mispredict) begin
                        flush_rem_nxt = FLUSH_RELOAD;
                    end else if (flush_rem <= 2'd1) begin
                        state_nxt     = RUN;
                        flush_rem_nxt = 2'd0;
                    end else begin
                        flush_rem_nxt = flush_rem - 2'd1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign pc_stall      = rst && (stall_set || lu_set);
    assign if_id_stall   = rst && (stall_set || lu_set);
    assign id_ex_bubble  = rst && lu_set;
    assign ex_mem_hold   = rst && stall_set;
    assign mem_wb_bubble = rst && stall_set;
    assign if_id_flush   = rst && flush_set;
    assign id_ex_flush   = rst && flush_set;

    // Sequencing registers; reset aborts any wait or flush and drops pending work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            flush_rem   <= 2'd0;
            pending     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            flush_rem   <= flush_rem_nxt;
            pending     <= pending_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            stall_cycles <= stall_cycles + 32'(pc_stall);
            flush_count  <= flush_count + 32'(mispredict);
        end
    end
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule
